// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Holds the INIT/RUN state type, default geometry and the sweep fill value.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Replicated to DATA_W bits when the post-reset sweep clears an entry.
  localparam logic SWEEP_FILL = 1'b0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for decode hazard detection: set on issue, cleared
// by write-back (set wins on a same-cycle collision), plus per-read-port lookup.
module regfile_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        pend_lookup
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // NOTE: always_comb uses blocking assignments; later statements override
  // earlier ones, which is exactly how the issue set beats the write clear.
  always_comb begin
    pending_nxt = pending;
    if (!run) begin
      pending_nxt = '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k]) pending_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (iss_en && (iss_addr != '0)) pending_nxt[iss_addr] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  always_comb begin
    pend_lookup = '0;
    for (int p = 0; p < NRD; p++) begin
      pend_lookup[p] = pending[rd_addr[p*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with post-reset clearing sweep and
// pending scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle write data.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  init_done
);

  localparam int NUM_REGS = 1 << ADDR_W;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   sweep_cnt;
  logic                run;
  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [ADDR_W-1:0]   wa [NWR];
  logic [DATA_W-1:0]   wd [NWR];
  logic [ADDR_W-1:0]   ra [NRD];
  logic [NRD-1:0]      pend_lookup;

  assign run       = (state == RUN);
  assign init_done = run;

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wa[k] = wr_addr[k*ADDR_W +: ADDR_W];
      wd[k] = wr_data[k*DATA_W +: DATA_W];
    end
    for (int p = 0; p < NRD; p++) begin
      ra[p] = rd_addr[p*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (&sweep_cnt) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // NOTE: the storage array has no reset; the INIT sweep clears it instead,
  // keeping the array mappable onto plain flops or RAM without a reset net.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[sweep_cnt] <= {DATA_W{SWEEP_FILL}};
    end else begin
      // Ascending loop: the highest-index port's update is the one that sticks.
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && (wa[k] != '0)) mem[wa[k]] <= wd[k];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .NWR    (NWR)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .pend_lookup (pend_lookup)
  );

  // NOTE: every output of this block gets a default first so no path through
  // the loop can leave a bit unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (run && rd_en[p] && (ra[p] != '0)) begin
        rd_data[p*DATA_W +: DATA_W] = mem[ra[p]];
        rd_busy[p]                  = pend_lookup[p];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && (wa[k] == ra[p])) begin
            rd_data[p*DATA_W +: DATA_W] = wd[k];
            rd_busy[p]                  = iss_en && (iss_addr == ra[p]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed test-plan steps plus randomized
// traffic checked against an array-based reference model of the register file.
module tb_regfile_mp;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NRD      = 2;
  localparam int NWR      = 2;
  localparam int NUM_REGS = 1 << ADDR_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NWR-1:0]        wr_en;
  logic [ADDR_W-1:0]     wa [NWR];
  logic [DATA_W-1:0]     wd [NWR];
  logic [NRD-1:0]        rd_en;
  logic [ADDR_W-1:0]     ra [NRD];
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  init_done;

  assign wr_addr = {wa[1], wa[0]};
  assign wr_data = {wd[1], wd[0]};
  assign rd_addr = {ra[1], ra[0]};

  regfile_mp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .NWR    (NWR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, pending flags, and cycles swept so far.
  logic [DATA_W-1:0] m_mem [NUM_REGS];
  bit                m_pend [NUM_REGS];
  int                init_cnt;
  int                n_cmp;
  int                n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    init_cnt = 0;
    for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_read(input int p, output logic [DATA_W-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (init_cnt < NUM_REGS || !rd_en[p] || ra[p] == '0) return;
    d = m_mem[ra[p]];
    b = m_pend[ra[p]];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k] && wa[k] == ra[p]) begin
        d = wd[k];
        b = iss_en && (iss_addr == ra[p]);
      end
    end
`endif
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if (init_cnt < NUM_REGS) begin
      m_mem[init_cnt] = '0;
      init_cnt++;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k]) begin
          if (wa[k] != '0) m_mem[wa[k]] = wd[k];
          m_pend[wa[k]] = 1'b0;
        end
      end
      if (iss_en && iss_addr != '0) m_pend[iss_addr] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic [DATA_W-1:0] ed;
    logic              eb;
    for (int p = 0; p < NRD; p++) begin
      model_read(p, ed, eb);
      check($sformatf("rd_data[%0d] a=%0d", p, ra[p]), rd_data[p*DATA_W +: DATA_W], ed);
      check($sformatf("rd_busy[%0d] a=%0d", p, ra[p]), 32'(rd_busy[p]), 32'(eb));
    end
    check("init_done", 32'(init_done), 32'(init_cnt == NUM_REGS));
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    rd_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic rand_inputs(input int max_addr);
    wr_en    = NWR'($urandom);
    rd_en    = NRD'($urandom);
    iss_en   = 1'($urandom);
    iss_addr = ADDR_W'($urandom_range(0, max_addr));
    for (int k = 0; k < NWR; k++) begin
      wa[k] = ADDR_W'($urandom_range(0, max_addr));
      wd[k] = $urandom;
    end
    for (int p = 0; p < NRD; p++) ra[p] = ADDR_W'($urandom_range(0, max_addr));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("init_done async drop", 32'(init_done), 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < NUM_REGS; i++) m_mem[i] = '0;
    model_reset();
    idle();
    iss_addr = '0;
    for (int k = 0; k < NWR; k++) begin wa[k] = '0; wd[k] = '0; end
    for (int p = 0; p < NRD; p++) ra[p] = '0;

    // Reset, then the full sweep with junk traffic that must be ignored.
    repeat (2) @(posedge clk);
    #1;
    check("reset init_done", 32'(init_done), 32'h0);
    release_reset();
    for (int c = 0; c < NUM_REGS; c++) begin
      rand_inputs(NUM_REGS - 1);
      cycle();
    end
    idle();
    #2;
    check("init_done after sweep", 32'(init_done), 32'h1);
    cycle();

    // r5 written on port 0, read on port 1 one cycle later.
    wr_en = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
    cycle();
    idle(); rd_en = 2'b10; ra[1] = 5'd5;
    #2;
    check("r5 via port1", rd_data[2*DATA_W-1:DATA_W], 32'hDEADBEEF);
    cycle();

    // r0 write is discarded.
    idle(); wr_en = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1234;
    cycle();
    idle(); rd_en = 2'b01; ra[0] = 5'd0;
    #2;
    check("r0 reads zero", rd_data[DATA_W-1:0], 32'h0);
    cycle();

    // Same-address collision: port 1 wins.
    idle(); wr_en = 2'b11; wa[0] = 5'd7; wd[0] = 32'h1111; wa[1] = 5'd7; wd[1] = 32'h2222;
    cycle();
    idle(); rd_en = 2'b01; ra[0] = 5'd7;
    #2;
    check("r7 collision", rd_data[DATA_W-1:0], 32'h2222);
    cycle();

    // Scoreboard: mark, clear by write, then set beats clear.
    idle(); iss_en = 1'b1; iss_addr = 5'd9;
    cycle();
    idle(); rd_en = 2'b01; ra[0] = 5'd9;
    #2;
    check("r9 busy after iss", 32'(rd_busy[0]), 32'h1);
    cycle();
    idle(); wr_en = 2'b10; wa[1] = 5'd9; wd[1] = 32'h99;
    cycle();
    idle(); rd_en = 2'b01; ra[0] = 5'd9;
    #2;
    check("r9 busy cleared", 32'(rd_busy[0]), 32'h0);
    cycle();
    idle(); iss_en = 1'b1; iss_addr = 5'd9; wr_en = 2'b01; wa[0] = 5'd9; wd[0] = 32'hAA;
    cycle();
    idle(); rd_en = 2'b01; ra[0] = 5'd9;
    #2;
    check("r9 set wins", 32'(rd_busy[0]), 32'h1);
    check("r9 data", rd_data[DATA_W-1:0], 32'hAA);
    cycle();

    // Write-to-read timing on r3.
    idle(); wr_en = 2'b01; wa[0] = 5'd3; wd[0] = 32'h77;
    cycle();
    idle(); wr_en = 2'b01; wa[0] = 5'd3; wd[0] = 32'hCAFE; rd_en = 2'b01; ra[0] = 5'd3;
    #2;
`ifdef REGFILE_BYPASS_EN
    check("r3 same-cycle", rd_data[DATA_W-1:0], 32'hCAFE);
`else
    check("r3 same-cycle", rd_data[DATA_W-1:0], 32'h77);
`endif
    cycle();
    idle(); rd_en = 2'b01; ra[0] = 5'd3;
    #2;
    check("r3 next cycle", rd_data[DATA_W-1:0], 32'hCAFE);
    cycle();

    // Randomized traffic; narrow address range first to force collisions.
    for (int c = 0; c < 300; c++) begin
      rand_inputs(7);
      cycle();
    end
    for (int c = 0; c < 300; c++) begin
      rand_inputs(NUM_REGS - 1);
      cycle();
    end

    // Leave several registers pending, then reset mid-operation and mid-sweep.
    for (int a = 1; a < 8; a++) begin
      idle(); iss_en = 1'b1; iss_addr = ADDR_W'(a);
      cycle();
    end
    idle();
    assert_reset();
    cycle();
    cycle();
    release_reset();
    for (int c = 0; c < 10; c++) begin
      rand_inputs(NUM_REGS - 1);
      cycle();
    end
    assert_reset();
    cycle();
    cycle();
    release_reset();
    for (int c = 0; c < NUM_REGS; c++) begin
      rand_inputs(NUM_REGS - 1);
      cycle();
    end
    idle();
    #2;
    check("init_done after restart", 32'(init_done), 32'h1);

    // Every entry cleared and nothing pending after the restarted sweep.
    for (int a = 0; a < NUM_REGS; a += 2) begin
      idle(); rd_en = 2'b11; ra[0] = ADDR_W'(a); ra[1] = ADDR_W'(a + 1);
      #1;
      check($sformatf("clear r%0d", a + 1), rd_data[2*DATA_W-1:DATA_W], 32'h0);
      check($sformatf("busy r%0d", a + 1), 32'(rd_busy[1]), 32'h0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the pipeline's decode stage (stage 2), successor to the fixed 32×32 two-read/one-write file. It adds:
- configurable data width, depth, read-port count and write-port count;
- a post-reset clearing sweep that zeroes every entry, not only r0;
- a per-register pending scoreboard that decode uses to detect in-flight producers.

Writes arrive from write-back. Reads and issue marks come from the decode logic in the same stage.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; NUM_REGS = 2**ADDR_W
- NRD, 2: number of read ports
- NWR, 2: number of write ports; higher index has higher priority
- clk  input  1  clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- wr_en  input  NWR  per-port write enable
- wr_addr  input  NWR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W]
- wr_data  input  NWR*DATA_W  write data, same packing
- rd_en  input  NRD  per-port read enable
- rd_addr  input  NRD*ADDR_W  read addresses
- rd_data  output  NRD*DATA_W  read data (combinational)
- rd_busy  output  NRD  destination of the read port's address is still pending
- iss_en  input  1  mark a destination register pending
- iss_addr  input  ADDR_W  register to mark
- init_done  output  1  high once the clearing sweep has finished

## Operation
- FSM states are INIT and RUN.
- **INIT (entered on reset)**
  - A counter sweeps addresses 0..NUM_REGS-1, writing zero to one entry per cycle.
  - wr_en and iss_en are ignored.
  - All pending bits are held at 0.
  - rd_data = 0, rd_busy = 0, init_done = 0.
- **INIT → RUN:** the transition occurs after the cycle that clears address NUM_REGS-1. init_done rises with RUN and stays high until the next reset.
- **Writes (RUN only)**
  - Writes to address 0 are discarded, so r0 always reads 0.
  - If several enabled ports target the same address, the highest-index port's data is stored.
- **Scoreboard**
  - iss_en sets pending[iss_addr]; a mark on address 0 is ignored.
  - Any enabled write to an address clears its pending bit.
  - If iss_en and a write hit the same address in the same cycle, the set wins (a new producer is in flight).
- **Reads (combinational)**
  - rd_en = 0 or address 0 → rd_data = 0 and rd_busy = 0.
  - Otherwise the port returns the stored entry; bypass behaviour is described under Configuration.
  - Without bypass, rd_busy = pending[addr].
- **Reset mid-operation** (asserted in either state): the FSM returns to INIT immediately, the counter returns to 0, all pending bits clear, and init_done drops.

## Timing
- Reset values: init_done = 0, all pending bits = 0, FSM = INIT, counter = 0. rd_data and rd_busy read 0 while in INIT.
- The sweep takes exactly NUM_REGS cycles after rst_n deasserts, so init_done is high on cycle NUM_REGS.
- Write latency is 1 cycle: an entry written at edge N is readable after edge N.
- Issue latency is 1 cycle: rd_busy reflects a mark from the following cycle onward.
- No stall or handshake: a write is accepted every cycle on every port.

## Configuration
- REGFILE_BYPASS_EN defined: read ports forward same-cycle write data.
  - Forwarding applies when an enabled write port matches a nonzero read address.
  - rd_data returns the highest-priority matching wr_data (0-cycle write-to-read).
  - rd_busy is 0 for that port unless iss_en marks the same address in the same cycle.
- Macro undefined: reads see only stored state, and rd_busy = pending[addr] exactly.

## Structure
- Shared package regfile_pkg holds:
  - the FSM state typedef (INIT, RUN);
  - default DATA_W and ADDR_W constants;
  - the zero constant used by the sweep.
- One sub-module, regfile_scoreboard: NUM_REGS pending bits, the set/clear priority logic, and the per-port busy lookup.
- The storage array, write-priority resolution, read muxes and FSM remain in regfile_mp.

## Test plan
- Reset release, default parameters: init_done low for cycles 0–31, high at cycle 32; rd_data reads 0 throughout INIT.
- After init: write 0xDEADBEEF to r5 on port 0 → next cycle a port-1 read of r5 returns 0xDEADBEEF. Write 0x1234 to r0 → r0 still reads 0.
- Dual write collision: port 0 writes 0x1111 and port 1 writes 0x2222 to r7 in one cycle → r7 reads 0x2222.
- Scoreboard: iss r9 → rd_busy = 1 next cycle; write r9 → busy clears. iss and write to r9 in the same cycle → busy stays 1.
- With REGFILE_BYPASS_EN: write 0xCAFE to r3 while reading r3 in the same cycle → rd_data = 0xCAFE that cycle. Without the macro → the old value that cycle, 0xCAFE next cycle.
- Assert rst_n low at sweep count 10, release → sweep restarts from 0, init_done rises 32 cycles after release, and all pending bits are 0.
